// File: rtl/nibbler_fetch_ctrl.sv
// Fetch/execute sequencer for the Nibbler CPU: steps the program counter,
// latches instruction/operand bytes from ROM and strobes the execute stage.
module nibbler_fetch_ctrl #(
    parameter int PC_W = 12,
    parameter int IW   = 8
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    input  logic [IW-1:0]   prog_byte,
    input  logic            flag_c,
    input  logic            flag_z,
    output logic            pc_enable,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_load_addr,
    output logic [IW-1:0]   instr,
    output logic [IW-1:0]   operand,
    output logic            exec_strobe,
    output logic            halted,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        FETCH2 = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            step_q;
    logic            step_pulse;
    logic            taken;
    logic [3:0]      opcode;
    logic [PC_W-1:0] target;

    // Conditional/unconditional jumps (0xA-0xE) carry a second address byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

    function automatic logic jump_taken(input logic [3:0] op, input logic c, input logic z);
        case (op)
            4'hA:    return c;
            4'hB:    return ~c;
            4'hC:    return z;
            4'hD:    return ~z;
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign step_pulse = step & ~step_q;
    assign opcode     = instr[7:4];
    assign target     = PC_W'({instr[3:0], operand});
    assign taken      = jump_taken(opcode, flag_c, flag_z);
    assign state_o    = state_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            instr   <= '0;
            operand <= '0;
        end else begin
            if (state_q == FETCH)
                instr <= prog_byte;
            if (state_q == FETCH2)
                operand <= prog_byte;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_enable    = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        exec_strobe  = 1'b0;
        halted       = 1'b0;
        case (state_q)
            IDLE: begin
                if (run || step_pulse)
                    state_d = FETCH;
            end
            FETCH: begin
                pc_enable = 1'b1;
                state_d   = is_two_byte(prog_byte[7:4]) ? FETCH2 : EXEC;
            end
            FETCH2: begin
                pc_enable = 1'b1;
                state_d   = EXEC;
            end
            EXEC: begin
                exec_strobe = 1'b1;
                pc_load     = taken;
                if (taken)
                    pc_load_addr = target;
                // Dropping to IDLE without run is what makes step mode one-shot.
                if (opcode == 4'hF)
                    state_d = HALT;
                else if (run)
                    state_d = FETCH;
                else
                    state_d = IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nibbler_fetch_ctrl.sv
// Bench for nibbler_fetch_ctrl: ROM + program counter model around the DUT,
// expected execute strobes queued by stimulus and checked by a monitor.
module tb_nibbler_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        flag_c = 1'b0;
    logic        flag_z = 1'b0;
    logic [7:0]  prog_byte;
    logic        pc_enable, pc_load, exec_strobe, halted;
    logic [11:0] pc_load_addr;
    logic [7:0]  instr, operand;
    logic [2:0]  state_o;

    logic [7:0]  rom [0:4095];
    logic [11:0] pc;

    typedef struct {
        logic [7:0]  instr;
        logic        ld;
        logic [11:0] addr;
        logic        chk_op;
        logic [7:0]  op;
        int          gap;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int execs = 0;
    int cyc = 0;
    int last_cyc = 0;
    int base;

    nibbler_fetch_ctrl #(.PC_W(12), .IW(8)) dut (
        .CLK(CLK), .reset(reset), .run(run), .step(step),
        .prog_byte(prog_byte), .flag_c(flag_c), .flag_z(flag_z),
        .pc_enable(pc_enable), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
        .instr(instr), .operand(operand), .exec_strobe(exec_strobe),
        .halted(halted), .state_o(state_o)
    );

    always #5 CLK = ~CLK;

    assign prog_byte = rom[pc];

    always @(posedge CLK or negedge reset) begin
        if (!reset)         pc <= 12'h000;
        else if (pc_load)   pc <= pc_load_addr;
        else if (pc_enable) pc <= pc + 12'd1;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] i, input logic ld, input logic [11:0] a,
                        input logic chk, input logic [7:0] op, input int gap);
        exp_t e;
        e.instr = i; e.ld = ld; e.addr = a; e.chk_op = chk; e.op = op; e.gap = gap;
        q.push_back(e);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (reset && exec_strobe) begin
            execs++;
            if (q.size() == 0) begin
                check("unexpected_exec", {24'h0, instr}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("exec_instr", {24'h0, instr}, {24'h0, e.instr});
                check("exec_pc_load", {31'h0, pc_load}, {31'h0, e.ld});
                check("exec_pc_load_addr", {20'h0, pc_load_addr}, {20'h0, e.addr});
                check("exec_pc_enable_low", {31'h0, pc_enable}, 32'h0);
                if (e.chk_op)
                    check("exec_operand", {24'h0, operand}, {24'h0, e.op});
                if (e.gap != 0)
                    check("exec_period", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge CLK); #2;
        reset = 1'b0;
        run = 1'b0;
        step = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
    endtask

    task automatic release_reset(input logic r);
        run = r;
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        #2;
        check(name, q.size(), 0);
    endtask

    initial begin
        clear_rom();
        // Reset state and idle hold
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", {pc_enable, pc_load, pc_load_addr, instr, operand,
                                exec_strobe, halted, state_o}, 32'h0);
        @(posedge CLK); #2;
        release_reset(1'b0);
        repeat (10) @(posedge CLK);
        #2;
        check("idle_state", {29'h0, state_o}, 32'd0);
        check("idle_no_exec", execs, 0);
        check("idle_pc_still", {20'h0, pc}, 32'h000);

        // Free-run program: one-byte ops, JMP, untaken JZ/JNC, taken JC, HALT
        do_reset();
        clear_rom();
        rom[12'h000] = 8'h12; rom[12'h001] = 8'h37;
        rom[12'h002] = 8'hE3; rom[12'h003] = 8'h45;
        rom[12'h345] = 8'hC1; rom[12'h346] = 8'h20;
        rom[12'h347] = 8'hB5; rom[12'h348] = 8'h55;
        rom[12'h349] = 8'hA1; rom[12'h34A] = 8'h20;
        rom[12'h120] = 8'hF0;
        flag_c = 1'b1; flag_z = 1'b0;
        push(8'h12, 1'b0, 12'h000, 1'b0, 8'h00, 0);
        push(8'h37, 1'b0, 12'h000, 1'b0, 8'h00, 2);
        push(8'hE3, 1'b1, 12'h345, 1'b1, 8'h45, 3);
        push(8'hC1, 1'b0, 12'h000, 1'b1, 8'h20, 3);
        push(8'hB5, 1'b0, 12'h000, 1'b1, 8'h55, 3);
        push(8'hA1, 1'b1, 12'h120, 1'b1, 8'h20, 3);
        push(8'hF0, 1'b0, 12'h000, 1'b0, 8'h00, 2);
        release_reset(1'b1);
        wait_drain("drain_prog_a", 60);
        @(posedge CLK); #2;
        check("halt_flag", {31'h0, halted}, 32'd1);
        check("halt_state", {29'h0, state_o}, 32'd4);
        base = execs;
        for (int i = 0; i < 6; i++) begin
            step = ~step;
            @(posedge CLK); #2;
        end
        step = 1'b0;
        check("halt_sticky", {31'h0, halted}, 32'd1);
        check("halt_no_exec", execs, base);
        check("halt_no_pc_strobes", {30'h0, pc_enable, pc_load}, 32'd0);
        reset = 1'b0;
        #1;
        check("reset_clears_halt", {28'h0, halted, state_o}, 32'd0);

        // Taken JZ
        do_reset();
        clear_rom();
        rom[12'h000] = 8'hC1; rom[12'h001] = 8'h20;
        rom[12'h120] = 8'hF0;
        flag_c = 1'b0; flag_z = 1'b1;
        push(8'hC1, 1'b1, 12'h120, 1'b1, 8'h20, 0);
        push(8'hF0, 1'b0, 12'h000, 1'b0, 8'h00, 2);
        release_reset(1'b1);
        wait_drain("drain_prog_b", 30);

        // Single-step with a long step pulse, then a second edge
        do_reset();
        clear_rom();
        rom[12'h000] = 8'h12; rom[12'h001] = 8'h37; rom[12'h002] = 8'h55;
        flag_z = 1'b0;
        release_reset(1'b0);
        repeat (2) @(posedge CLK); #2;
        base = execs;
        push(8'h12, 1'b0, 12'h000, 1'b0, 8'h00, 0);
        step = 1'b1;
        repeat (5) @(posedge CLK);
        #2;
        step = 1'b0;
        repeat (4) @(posedge CLK);
        #2;
        check("step1_one_exec", execs - base, 1);
        check("step1_idle", {29'h0, state_o}, 32'd0);
        check("step1_pc", {20'h0, pc}, 32'h001);
        push(8'h37, 1'b0, 12'h000, 1'b0, 8'h00, 0);
        step = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        step = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        check("step2_one_more_exec", execs - base, 2);
        check("step2_pc", {20'h0, pc}, 32'h002);
        check("step_queue_empty", q.size(), 0);

        // Reset asserted in FETCH2
        do_reset();
        clear_rom();
        rom[12'h000] = 8'hE3; rom[12'h001] = 8'h45;
        release_reset(1'b1);
        begin
            int n = 0;
            while (state_o != 3'd2 && n < 10) begin
                @(negedge CLK);
                n++;
            end
        end
        check("reached_fetch2", {29'h0, state_o}, 32'd2);
        base = execs;
        #1;
        reset = 1'b0;
        #1;
        check("midop_reset_outputs", {pc_enable, pc_load, pc_load_addr, instr, operand,
                                      exec_strobe, halted, state_o}, 32'h0);
        run = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        reset = 1'b1;
        repeat (5) @(posedge CLK);
        #2;
        check("midop_no_exec", execs, base);
        check("midop_idle", {29'h0, state_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
